// File: rtl/opcode_stream_assembler.sv
// Byte-serial retired-opcode assembler. Joins the 0xff extended prefix with its
// second byte, presents opcode_1/opcode_2/valid_op for the instruction monitor,
// keeps retire statistics and runs a no-retire hang watchdog.
module opcode_stream_assembler #(
  parameter int WDOG_CYCLES = 10000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             flush,
  input  logic             wdog_en,
  output logic [7:0]       opcode_1,
  output logic [7:0]       opcode_2,
  output logic             valid_op,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] ext_count,
  output logic [15:0]      drop_count,
  output logic             hang
);

  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);

  typedef enum logic {IDLE, EXT} state_t;

  state_t        state, state_next;
  logic          emit, emit_ext, drop_inc;
  logic [7:0]    op1_next, op2_next;
  logic [WW-1:0] wdog_cnt;

  // Next-state decode: flush beats byte_valid; a prefix waits in EXT.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    drop_inc   = 1'b0;
    op1_next   = opcode_1;
    op2_next   = opcode_2;
    if (flush) begin
      state_next = IDLE;
      drop_inc   = (state == EXT);
    end else if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == 8'hff) begin
            state_next = EXT;
          end else begin
            emit     = 1'b1;
            op1_next = byte_data;
            op2_next = 8'h00;
          end
        end
        EXT: begin
          state_next = IDLE;
          emit       = 1'b1;
          emit_ext   = 1'b1;
          op1_next   = 8'hff;
          op2_next   = byte_data;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, registered opcode outputs and retire statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      opcode_1   <= 8'h00;
      opcode_2   <= 8'h00;
      valid_op   <= 1'b0;
      inst_count <= '0;
      ext_count  <= '0;
      drop_count <= 16'h0000;
    end else begin
      state    <= state_next;
      opcode_1 <= op1_next;
      opcode_2 <= op2_next;
      valid_op <= emit;
      if (emit)     inst_count <= inst_count + 1'b1;
      if (emit_ext) ext_count  <= ext_count + 1'b1;
      if (drop_inc && drop_count != 16'hffff) drop_count <= drop_count + 16'h0001;
    end
  end

  // Watchdog: the counter reads 0 in every cycle valid_op is high, otherwise
  // counts up and parks at WDOG_CYCLES; hang latches one cycle after that.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      hang     <= 1'b0;
    end else begin
      if (wdog_cnt == WDOG_MAX) hang <= 1'b1;
      if (!wdog_en || emit)          wdog_cnt <= '0;
      else if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_opcode_stream_assembler.sv
// Bench for opcode_stream_assembler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model.
module tb_opcode_stream_assembler;

  localparam int WD = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1, byte_valid = 1'b0, flush = 1'b0, wdog_en = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic [7:0]    opcode_1, opcode_2;
  logic          valid_op, hang;
  logic [CW-1:0] inst_count, ext_count;
  logic [15:0]   drop_count;

  int checks = 0, errors = 0;

  opcode_stream_assembler #(.WDOG_CYCLES(WD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .flush(flush), .wdog_en(wdog_en), .opcode_1(opcode_1), .opcode_2(opcode_2),
    .valid_op(valid_op), .inst_count(inst_count), .ext_count(ext_count),
    .drop_count(drop_count), .hang(hang)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a pending-prefix flag, expected output values, plain
  // integer tallies, and the number of cycles since the last strobe.
  bit       started = 0;
  bit       m_pend = 0, m_vld = 0, m_hang = 0;
  bit [7:0] m_op1 = 0, m_op2 = 0;
  int       m_inst = 0, m_ext = 0, m_drop = 0, m_quiet = 0;

  // Single compare process: advance the model on each edge, check shortly after.
  always @(posedge clk) begin
    bit emit;
    emit = 0;
    if (reset) begin
      started = 1;
      m_pend = 0; m_vld = 0; m_hang = 0; m_op1 = 0; m_op2 = 0;
      m_inst = 0; m_ext = 0; m_drop = 0; m_quiet = 0;
    end else begin
      if (flush) begin
        if (m_pend && m_drop < 65535) m_drop++;
        m_pend = 0;
      end else if (byte_valid) begin
        if (m_pend) begin
          emit = 1; m_op1 = 8'hff; m_op2 = byte_data; m_ext++; m_pend = 0;
        end else if (byte_data == 8'hff) begin
          m_pend = 1;
        end else begin
          emit = 1; m_op1 = byte_data; m_op2 = 8'h00;
        end
      end
      if (emit) m_inst++;
      m_vld = emit;
      if (m_quiet >= WD) m_hang = 1;
      m_quiet = (!wdog_en || emit) ? 0 : (m_quiet >= WD ? WD : m_quiet + 1);
    end
    #1;
    if (started) begin
      chk("valid_op", valid_op, m_vld);
      chk("opcode_1", opcode_1, m_op1);
      chk("opcode_2", opcode_2, m_op2);
      chk("inst_count", inst_count, m_inst % (1 << CW));
      chk("ext_count", ext_count, m_ext % (1 << CW));
      chk("drop_count", drop_count, m_drop);
      chk("hang", hang, m_hang);
    end
  end

  // Drive one cycle of inputs on the falling edge, return just after the rise.
  task automatic step(input bit r, input bit bv, input logic [7:0] bd, input bit fl, input bit we);
    @(negedge clk);
    reset = r; byte_valid = bv; byte_data = bd; flush = fl; wdog_en = we;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit we);
    step(0, 0, 8'h00, 0, we);
  endtask

  initial begin
    // Reset state and three back-to-back simple opcodes.
    step(1, 0, 8'h00, 0, 0);
    chk("rst_valid", valid_op, 0); chk("rst_op1", opcode_1, 0); chk("rst_op2", opcode_2, 0);
    chk("rst_inst", inst_count, 0); chk("rst_hang", hang, 0);
    step(0, 1, 8'h10, 0, 0); chk("s1_v", valid_op, 1); chk("s1_op1", opcode_1, 8'h10); chk("s1_op2", opcode_2, 0);
    step(0, 1, 8'h60, 0, 0); chk("s2_v", valid_op, 1); chk("s2_op1", opcode_1, 8'h60);
    step(0, 1, 8'hb1, 0, 0); chk("s3_v", valid_op, 1); chk("s3_op1", opcode_1, 8'hb1);
    idle(0); chk("s_idle_v", valid_op, 0); chk("s_inst", inst_count, 3); chk("s_ext", ext_count, 0);
    chk("s_hold_op1", opcode_1, 8'hb1);

    // Extended opcode back to back.
    step(0, 1, 8'hff, 0, 0); chk("e_pref_v", valid_op, 0);
    step(0, 1, 8'h2a, 0, 0); chk("e_v", valid_op, 1); chk("e_op1", opcode_1, 8'hff);
    chk("e_op2", opcode_2, 8'h2a); chk("e_ext", ext_count, 1);

    // Prefix, gap, then 0xff as the second byte.
    step(0, 1, 8'hff, 0, 0);
    for (int i = 0; i < 3; i++) begin idle(0); chk("gap_v", valid_op, 0); end
    step(0, 1, 8'hff, 0, 0); chk("ffff_v", valid_op, 1); chk("ffff_op1", opcode_1, 8'hff);
    chk("ffff_op2", opcode_2, 8'hff);
    idle(0); chk("ffff_single", valid_op, 0);

    // Flush drops a pending prefix and the byte arriving with it.
    step(0, 1, 8'hff, 0, 0);
    step(0, 1, 8'h05, 1, 0); chk("fl_v", valid_op, 0); chk("fl_drop", drop_count, 1);
    step(0, 1, 8'h05, 0, 0); chk("fl_after_v", valid_op, 1); chk("fl_after_op1", opcode_1, 8'h05);
    chk("fl_after_op2", opcode_2, 8'h00);
    step(0, 0, 8'h00, 1, 0); chk("fl_idle_drop", drop_count, 1);

    // Watchdog with no traffic: hang first visible in cycle 9.
    step(1, 0, 8'h00, 0, 1);
    for (int c = 0; c < 12; c++) begin
      idle(1);
      chk("wd_quiet", hang, (c + 1 >= 9) ? 1 : 0);
    end
    // An opcode strobing in cycle 5 pushes the rise to cycle 14.
    step(1, 0, 8'h00, 0, 1);
    for (int c = 0; c < 17; c++) begin
      if (c == 4) step(0, 1, 8'h33, 0, 1);
      else        idle(1);
      chk("wd_kick", hang, (c + 1 >= 14) ? 1 : 0);
    end
    // Watchdog disabled: never rises.
    step(1, 0, 8'h00, 0, 0);
    for (int c = 0; c < 20; c++) idle(0);
    chk("wd_off", hang, 0);

    // Reset while a prefix is pending, with seven opcodes already counted.
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(i + 1), 0, 0);
    step(0, 1, 8'hff, 0, 0);
    chk("pre_rst_inst", inst_count, 7);
    step(1, 1, 8'h44, 1, 0);
    chk("mr_v", valid_op, 0); chk("mr_op1", opcode_1, 0); chk("mr_inst", inst_count, 0);
    chk("mr_drop", drop_count, 0);
    step(0, 1, 8'h2a, 0, 0); chk("mr_after_op1", opcode_1, 8'h2a); chk("mr_after_op2", opcode_2, 0);
    chk("mr_after_v", valid_op, 1);

    // Randomized traffic; the model is checked on every cycle.
    for (int n = 0; n < 3000; n++) begin
      bit r, bv, fl, we;
      logic [7:0] bd;
      r  = ($urandom_range(0, 999) == 0);
      bv = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 19) == 0);
      we = ($urandom_range(0, 15) != 0);
      bd = ($urandom_range(0, 2) == 0) ? 8'hff : 8'($urandom);
      if ((n / 300) % 3 == 2) bv = ($urandom_range(0, 9) == 0);
      step(r, bv, bd, fl, we);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opcode_stream_assembler.md
Name: opcode_stream_assembler

Overview:
- Simulation-environment stage directly upstream of the instruction monitor.
- Takes the byte-serial retired-opcode stream tapped from the pipeline and assembles whole opcodes, joining the 0xff extended prefix with its second byte.
- Presents opcode_1/opcode_2/valid_op in the exact form the instruction monitor consumes.
- Also keeps retire statistics and runs a no-retire watchdog that flags a hung core.

Parameters:
- WDOG_CYCLES, 10000: cycles with no assembled opcode, while the watchdog is enabled, before hang asserts. Legal range 2 to 2^20-1.
- CNT_W, 32: width of inst_count and ext_count.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- byte_valid  input  1  byte_data carries one retired opcode byte this cycle.
- byte_data  input  8  opcode byte.
- flush  input  1  pipeline flush; discards any partial extended opcode.
- wdog_en  input  1  watchdog enable.
- opcode_1  output  8  first opcode byte, or 8'hff for an extended opcode.
- opcode_2  output  8  second byte of an extended opcode; 8'h00 otherwise.
- valid_op  output  1  single-cycle strobe: opcode_1/opcode_2 valid.
- inst_count  output  CNT_W  total opcodes emitted, wraps.
- ext_count  output  CNT_W  extended (0xff-prefixed) opcodes emitted, wraps.
- drop_count  output  16  prefixes discarded by flush, saturates at 16'hffff.
- hang  output  1  sticky watchdog expiry flag.

Behaviour:
- Reset (synchronous, active-high): outputs and counters take these values.
  - opcode_1 = 8'h00, opcode_2 = 8'h00, valid_op = 0.
  - All counters 0, hang = 0, FSM enters IDLE, watchdog counter 0.
  - Reset overrides every other input in the same cycle.
- All outputs are registered. Latency is 1 cycle from the completing byte to valid_op.
- FSM states:
  - IDLE: waiting for the first byte of an opcode.
  - EXT: 0xff prefix accepted, waiting for the second byte.
- Transitions, evaluated in priority order: reset, then flush, then byte_valid.
  - flush = 1, any state: go to IDLE, no valid_op next cycle. Any byte_valid in the same cycle is discarded. drop_count increments only if the state was EXT.
  - IDLE, byte_valid, byte_data != 8'hff: next cycle valid_op = 1, opcode_1 = byte_data, opcode_2 = 8'h00. inst_count increments. Stay in IDLE.
  - IDLE, byte_valid, byte_data == 8'hff: go to EXT, no output.
  - EXT, byte_valid: next cycle valid_op = 1, opcode_1 = 8'hff, opcode_2 = byte_data (8'hff included, giving 0xffff). inst_count and ext_count increment. Go to IDLE.
  - No byte_valid: hold state, valid_op = 0.
- opcode_1/opcode_2 hold their last values when valid_op = 0.
- Back-to-back bytes on consecutive cycles are accepted with no bubbles. Maximum rate is one simple opcode per cycle, or one extended opcode per two cycles.
- Counters: inst_count and ext_count wrap modulo 2^CNT_W. drop_count saturates.
- Watchdog:
  - wdog_en = 0: counter held at 0.
  - wdog_en = 1: counter cleared in any cycle that valid_op is driven 1, otherwise incremented.
  - When the counter reaches WDOG_CYCLES, hang sets the following cycle and stays set until reset. The counter stops at WDOG_CYCLES.
  - A byte sitting in EXT does not clear the watchdog; only emitted opcodes do.
- Reset mid-EXT discards the prefix without touching drop_count, since drop_count is cleared by the reset.

Test Plan:
- Reset, then bytes 0x10, 0x60, 0xb1 on three consecutive cycles. Required: valid_op high on cycles 1-3 with opcode_1 = 0x10/0x60/0xb1 and opcode_2 = 0x00; inst_count = 3, ext_count = 0.
- Bytes 0xff then 0x2a consecutively. Required: no strobe after 0xff; one strobe with opcode_1 = 0xff, opcode_2 = 0x2a; ext_count = 1.
- Bytes 0xff, idle 3 cycles, then 0xff. Required: a single strobe carrying 0xff/0xff, delivered one cycle after the second 0xff.
- Byte 0xff, then flush together with byte_valid = 1, byte 0x05. Required: no strobe, drop_count = 1, state IDLE. A following byte 0x05 yields opcode_1 = 0x05.
- WDOG_CYCLES = 8, wdog_en = 1, no bytes. Required: hang rises on cycle 9 and stays high. An opcode emitted at cycle 5 instead delays the rise to cycle 14. With wdog_en = 0, hang never rises.
- Assert reset while in EXT with inst_count = 7. Required: all outputs and counters 0 the next cycle, and a following 0x2a is emitted as a simple opcode (opcode_1 = 0x2a).
